// File: rtl/arith_pkg.sv
// rtl/arith_pkg.sv - shared state encodings and helpers for the iterative arithmetic units
package arith_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Bits needed to hold the values 0..value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/twos_abs.sv
// rtl/twos_abs.sv - magnitude and sign extraction of a two's complement or unsigned operand
module twos_abs #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_signed,
    output logic [WIDTH-1:0] o_mag,
    output logic             o_neg
);

    logic w_neg;

    assign w_neg = i_signed & i_x[WIDTH-1];
    // The most negative value maps to 2^(WIDTH-1), which still fits as unsigned.
    assign o_mag = w_neg ? (~i_x + WIDTH'(1)) : i_x;
    assign o_neg = w_neg;

endmodule

// File: rtl/seq_mult.sv
// rtl/seq_mult.sv - iterative radix-2 shift-add multiplier with start/done handshake
module seq_mult
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic               w_last;

    twos_abs #(.WIDTH(WIDTH)) u_abs_a (
        .i_x      (a),
        .i_signed (signed_mode),
        .o_mag    (w_a_mag),
        .o_neg    (w_a_neg)
    );

    twos_abs #(.WIDTH(WIDTH)) u_abs_b (
        .i_x      (b),
        .i_signed (signed_mode),
        .o_mag    (w_b_mag),
        .o_neg    (w_b_neg)
    );

    // Low half of the accumulator holds the remaining multiplier bits; its LSB gates the add.
    assign w_addend   = r_acc[0] ? r_mcand : '0;
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
    assign w_last     = (r_count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_mcand   <= '0;
            r_acc     <= '0;
            r_neg     <= 1'b0;
            r_product <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_acc   <= w_acc_next;
                    r_count <= r_count + CW'(1);
                    if (w_last) begin
                        r_state   <= ST_DONE;
                        r_product <= r_neg ? -w_acc_next : w_acc_next;
                    end
                end
                default: begin
                    if (start) begin
                        r_state <= ST_RUN;
                        r_mcand <= w_a_mag;
                        r_acc   <= {{WIDTH{1'b0}}, w_b_mag};
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_count <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign ready   = (r_state != ST_RUN);
    assign busy    = (r_state == ST_RUN);
    assign done    = (r_state == ST_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_seq_mult.sv
// tb/tb_seq_mult.sv - self-checking bench for seq_mult with vector table and scoreboard
module tb_seq_mult;

    localparam int W = 8;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           ready;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int errors;
    int done_cnt;
    logic prev_done;
    logic [2*W-1:0] sb[$];

    typedef struct {
        logic [W-1:0]   va;
        logic [W-1:0]   vb;
        logic           vmode;
        logic [2*W-1:0] vexp;
    } vec_t;

    vec_t vecs[12];

    seq_mult #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic m);
        logic signed [2*W-1:0] sx;
        logic signed [2*W-1:0] sy;
        logic signed [2*W-1:0] sp;
        if (m) begin
            sx = {{W{x[W-1]}}, x};
            sy = {{W{y[W-1]}}, y};
            sp = sx * sy;
            return sp;
        end
        return {{W{1'b0}}, x} * {{W{1'b0}}, y};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done actual=product %0h expected=no done", product);
            end else begin
                logic [2*W-1:0] e;
                e = sb.pop_front();
                if (product !== e) begin
                    errors++;
                    $display("FAIL product actual=%0h expected=%0h", product, e);
                end
            end
            checks++;
            if (prev_done) begin
                errors++;
                $display("FAIL done_width actual=2+ cycles expected=1 cycle");
            end
        end
        prev_done = done;
    end

    // Called at a negedge while ready=1; returns at the negedge where done is seen.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic m, input logic hold);
        int n;
        a = xa;
        b = xb;
        signed_mode = m;
        start = 1'b1;
        sb.push_back(model(xa, xb, m));
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        signed_mode = ~m;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n > 40) begin
                errors++;
                $display("FAIL timeout actual=no done expected=done within 9 cycles");
                break;
            end
        end
        start = 1'b0;
        check("latency", n, W + 1);
    endtask

    initial begin
        int base;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        prev_done = 1'b0;
        start = 1'b0;
        signed_mode = 1'b0;
        a = '0;
        b = '0;
        rst_n = 1'b0;

        vecs[0]  = '{8'd10,  8'd4,   1'b0, 16'd40};
        vecs[1]  = '{8'd255, 8'd255, 1'b0, 16'd65025};
        vecs[2]  = '{8'h80,  8'hFF,  1'b0, 16'h7F80};
        vecs[3]  = '{8'd10,  8'd4,   1'b1, 16'd40};
        vecs[4]  = '{8'hF6,  8'd4,   1'b1, 16'hFFD8};
        vecs[5]  = '{8'd10,  8'hFC,  1'b1, 16'hFFD8};
        vecs[6]  = '{8'hF6,  8'hFC,  1'b1, 16'd40};
        vecs[7]  = '{8'h80,  8'h80,  1'b1, 16'd16384};
        vecs[8]  = '{8'h80,  8'd1,   1'b1, 16'hFF80};
        vecs[9]  = '{8'd0,   8'hFB,  1'b1, 16'd0};
        vecs[10] = '{8'hFF,  8'hFF,  1'b1, 16'd1};
        vecs[11] = '{8'd0,   8'd0,   1'b0, 16'd0};

        repeat (3) @(negedge clk);
        check("rst_ready", {31'b0, ready}, 1);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_product", {16'b0, product}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table vectors, issued back-to-back so each new start lands in the DONE cycle.
        for (int i = 0; i < 12; i++) begin
            check($sformatf("model_vec%0d", i), {16'b0, model(vecs[i].va, vecs[i].vb, vecs[i].vmode)}, {16'b0, vecs[i].vexp});
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vmode, 1'b0);
            check($sformatf("table_vec%0d", i), {16'b0, product}, {16'b0, vecs[i].vexp});
        end
        @(negedge clk);
        check("idle_after_done", {30'b0, ready, busy}, 2'b10);

        // start held high through RUN produces exactly one operation.
        base = done_cnt;
        run_op(8'd7, 8'd9, 1'b0, 1'b1);
        repeat (12) @(negedge clk);
        check("hold_one_op", done_cnt - base, 1);
        check("hold_sb_empty", sb.size(), 0);

        // Reset asserted while count==3 aborts with no done pulse.
        base = done_cnt;
        a = 8'd3;
        b = 8'd5;
        signed_mode = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy", {31'b0, busy}, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'b0, ready}, 1);
        check("midrst_busy", {31'b0, busy}, 0);
        check("midrst_done", {31'b0, done}, 0);
        check("midrst_product", {16'b0, product}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("midrst_no_done", done_cnt - base, 0);
        run_op(8'hF9, 8'd6, 1'b1, 1'b0);
        check("after_rst_op", {16'b0, product}, {16'b0, 16'hFFD6});

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end
        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
